// File: rtl/decled_pkg.sv
// Shared types and defaults for the LED-pair scanner that feeds decled.
//   seq_state_t  : sequencer states
//   CODE_OFF     : code that turns every LED off
//   CODE_*_DEF   : default scan range and step period
package decled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_FORCED = 2'd3
  } seq_state_t;

  localparam logic [3:0] CODE_OFF     = 4'h0;
  localparam logic [3:0] CODE_MIN_DEF = 4'd1;
  localparam logic [3:0] CODE_MAX_DEF = 4'd8;
  localparam int         TICK_DIV_DEF = 2_700_000;

endpackage

// File: rtl/decled_seq_tick_gen.sv
// Step prescaler for the scanner.
//   clk, rst : clock, synchronous active-high reset
//   en       : count this cycle
//   clr      : force the count back to zero (wins over en)
//   tick     : high in the cycle where the count is at TICK_DIV-1 and en is
//              set; the count wraps to zero on that edge
module tick_gen #(
  parameter int TICK_DIV = 2_700_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_p0;

  assign tick = en && (cnt_p0 == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_p0 <= '0;
    end else if (en) begin
      cnt_p0 <= tick ? '0 : cnt_p0 + 1'b1;
    end
  end

endmodule

// File: rtl/decled_seq.sv
// Scanner sequencer driving the 4-bit code input of decled.
//   start_i/stop_i/pause_i : one-cycle control pulses
//   bounce_i               : 1 = reverse at the ends, 0 = wrap
//   dir_i                  : start direction, sampled on a fresh start
//   load_valid/load_code   : forced-code request, accepted when load_ready
//   load_ready             : high whenever the scanner is not running
//   code_o                 : registered code to decled
//   busy_o                 : registered, high while running
//   tick_o                 : registered, one-cycle pulse per step
module decled_seq
  import decled_pkg::*;
#(
  parameter int         TICK_DIV = TICK_DIV_DEF,
  parameter logic [3:0] CODE_MIN = CODE_MIN_DEF,
  parameter logic [3:0] CODE_MAX = CODE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       pause_i,
  input  logic       bounce_i,
  input  logic       dir_i,
  input  logic       load_valid,
  input  logic [3:0] load_code,
  output logic       load_ready,
  output logic [3:0] code_o,
  output logic       busy_o,
  output logic       tick_o
);

  seq_state_t state;
  logic       dir;      // 0 = counting up, 1 = counting down
  logic       xfer;
  logic       go_fresh;
  logic       pre_en;
  logic       pre_clr;
  logic       tick;
  logic [4:0] nxt;      // {next dir, next code}

  // Next position along the scan; returns {dir, code}.
  function automatic logic [4:0] step_code(input logic [3:0] c, input logic d,
                                           input logic b);
    logic [4:0] r;
    r = {d, c};
    if (!d) begin
      if (c >= CODE_MAX) r = b ? {1'b1, CODE_MAX - 4'd1} : {1'b0, CODE_MIN};
      else               r = {1'b0, c + 4'd1};
    end else begin
      if (c <= CODE_MIN) r = b ? {1'b0, CODE_MIN + 4'd1} : {1'b1, CODE_MAX};
      else               r = {1'b1, c - 4'd1};
    end
    return r;
  endfunction

  // load_ready depends on state only, so the handshake has no input-to-output path.
  assign load_ready = (state != ST_RUN);
  assign xfer       = load_valid && load_ready && !stop_i;
  assign go_fresh   = start_i && !stop_i && !xfer &&
                      (state == ST_IDLE || state == ST_FORCED);
  // Pausing holds the count, so a resume finishes the interrupted period.
  assign pre_en     = (state == ST_RUN) && !stop_i && !pause_i;
  assign pre_clr    = stop_i || xfer || go_fresh;
  assign nxt        = step_code(code_o, dir, bounce_i);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      dir    <= 1'b0;
      code_o <= CODE_OFF;
      busy_o <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      if (stop_i) begin
        state  <= ST_IDLE;
        code_o <= CODE_OFF;
        busy_o <= 1'b0;
      end else if (xfer) begin
        state  <= ST_FORCED;
        code_o <= load_code;
        busy_o <= 1'b0;
      end else if (go_fresh) begin
        state  <= ST_RUN;
        dir    <= dir_i;
        code_o <= dir_i ? CODE_MAX : CODE_MIN;
        busy_o <= 1'b1;
      end else begin
        case (state)
          ST_PAUSE: begin
            if (start_i) begin
              state  <= ST_RUN;
              busy_o <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause_i) begin
              state  <= ST_PAUSE;
              busy_o <= 1'b0;
            end else if (tick) begin
              dir    <= nxt[4];
              code_o <= nxt[3:0];
              tick_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
